// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register-bank responder: NUM_REGS read/write registers with byte strobes and per-register write pulses.
// Optional AXIL_REG_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi4_lite_reg_slave #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic [2:0]                     awprot,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic [2:0]                     arprot,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BYTE_BITS  = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = ADDR_WIDTH - BYTE_BITS;
    localparam logic [IDX_WIDTH:0] NUM_REGS_EXT = (IDX_WIDTH + 1)'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_SLVERR_EN
    localparam logic [1:0] RESP_RANGE = 2'b10;
`else
    localparam logic [1:0] RESP_RANGE = 2'b00;
`endif

    logic                  awHeld_q, wHeld_q;
    logic [IDX_WIDTH-1:0]  awIdx_q;
    logic [DATA_WIDTH-1:0] wData_q;
    logic [STRB_WIDTH-1:0] wStrb_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   wrPulse_q, wrPulse_d;

    logic                  awFire, wFire, arFire, commit;
    logic                  awInRange, arInRange;
    logic [IDX_WIDTH-1:0]  arIdx;
    logic [DATA_WIDTH-1:0] rdMux;
    logic                  unusedBits;

    assign unusedBits = ^{awprot, arprot, awaddr[BYTE_BITS-1:0], araddr[BYTE_BITS-1:0]};

    assign awFire    = awvalid & ~awHeld_q;
    assign wFire     = wvalid & ~wHeld_q;
    assign arFire    = arvalid & ~rvalid_q;
    assign commit    = awHeld_q & wHeld_q & ~bvalid_q;
    assign arIdx     = araddr[ADDR_WIDTH-1:BYTE_BITS];
    assign awInRange = {1'b0, awIdx_q} < NUM_REGS_EXT;
    assign arInRange = {1'b0, arIdx} < NUM_REGS_EXT;

    // Out-of-range indices match no register, so they neither write nor pulse.
    always_comb begin
        regs_d    = regs_q;
        wrPulse_d = '0;
        if (commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (awIdx_q == IDX_WIDTH'(i)) begin
                    wrPulse_d[i] = 1'b1;
                    for (int k = 0; k < STRB_WIDTH; k++) begin
                        if (wStrb_q[k]) regs_d[i][8*k +: 8] = wData_q[8*k +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        rdMux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (arIdx == IDX_WIDTH'(i)) rdMux = regs_q[i];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awHeld_q  <= 1'b0;
            wHeld_q   <= 1'b0;
            awIdx_q   <= '0;
            wData_q   <= '0;
            wStrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            wrPulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else begin
            regs_q    <= regs_d;
            wrPulse_q <= wrPulse_d;
            if (awFire) begin
                awHeld_q <= 1'b1;
                awIdx_q  <= awaddr[ADDR_WIDTH-1:BYTE_BITS];
            end
            if (wFire) begin
                wHeld_q <= 1'b1;
                wData_q <= wdata;
                wStrb_q <= wstrb;
            end
            // Commit only fires with both flags held, so it never overlaps a new latch.
            if (commit) begin
                awHeld_q <= 1'b0;
                wHeld_q  <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= awInRange ? RESP_OKAY : RESP_RANGE;
            end else if (bvalid_q && bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Reads sample regs_q before any same-edge commit lands, returning the old value.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (arFire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdMux;
            rresp_q  <= arInRange ? RESP_OKAY : RESP_RANGE;
        end else if (rvalid_q && rready) begin
            rvalid_q <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : gRegOut
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    assign awready  = ~awHeld_q;
    assign wready   = ~wHeld_q;
    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign arready  = ~rvalid_q;
    assign rvalid   = rvalid_q;
    assign rresp    = rresp_q;
    assign rdata    = rdata_q;
    assign wr_pulse = wrPulse_q;

endmodule
